// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the ball controller state encoding.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2
    } ball_state_e;

endpackage

// File: rtl/axis_step.sv
// One bounded axis: advances a position by step in the current direction,
// clamping and reflecting at 0 and max.
module axis_step (
    input  logic [9:0] pos,
    input  logic       dir,
    input  logic [9:0] step,
    input  logic [9:0] max,
    input  logic       low_is_miss,
    output logic [9:0] next_pos,
    output logic       next_dir,
    output logic       hit_low,
    output logic       hit_high
);

    // 11-bit sum so pos+step can never wrap before the compare.
    logic [10:0] sum;
    assign sum = {1'b0, pos} + {1'b0, step};

    // low_is_miss: the max end is the lost-ball edge (screen bottom), so it
    // clamps without reflecting; the parent decides what happens next.
    always_comb begin
        next_pos = pos;
        next_dir = dir;
        hit_low  = 1'b0;
        hit_high = 1'b0;
        if (dir) begin
            if (sum >= {1'b0, max}) begin
                next_pos = max;
                next_dir = low_is_miss ? dir : 1'b0;
                hit_high = 1'b1;
            end else begin
                next_pos = sum[9:0];
            end
        end else begin
            if (pos <= step) begin
                next_pos = '0;
                next_dir = 1'b1;
                hit_low  = 1'b1;
            end else begin
                next_pos = pos - step;
            end
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Tick-driven ball motion controller: serve, run with wall reflection,
// and a timed hold after a miss at the bottom edge.
module ball_motion
    import vga_pkg::*;
#(
    parameter int BALL_SIZE  = 8,
    parameter int STEP_X     = 4,
    parameter int STEP_Y     = 4,
    parameter int HOLD_TICKS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        enable,
    input  logic        start,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic        running,
    output logic        bounce,
    output logic        miss,
    output ball_state_e state_dbg
);

    localparam logic [9:0] XMAX   = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic [9:0] YMAX   = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0] X_CTR  = XMAX >> 1;
    localparam logic [9:0] Y_CTR  = YMAX >> 1;
    localparam int         HOLD_W = $clog2(HOLD_TICKS + 1);

    ball_state_e       state, state_n;
    logic              dx, dy, serve_dx;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_done;
    logic [9:0]        x_next, y_next;
    logic              dx_next, dy_next;
    logic              x_hit_low, x_hit_high, y_hit_low, y_hit_high;

    axis_step u_axis_x (
        .pos         (ball_x),
        .dir         (dx),
        .step        (10'(STEP_X)),
        .max         (XMAX),
        .low_is_miss (1'b0),
        .next_pos    (x_next),
        .next_dir    (dx_next),
        .hit_low     (x_hit_low),
        .hit_high    (x_hit_high)
    );

    axis_step u_axis_y (
        .pos         (ball_y),
        .dir         (dy),
        .step        (10'(STEP_Y)),
        .max         (YMAX),
        .low_is_miss (1'b1),
        .next_pos    (y_next),
        .next_dir    (dy_next),
        .hit_low     (y_hit_low),
        .hit_high    (y_hit_high)
    );

    assign hold_done = (hold_cnt == HOLD_W'(HOLD_TICKS - 1));
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= SERVE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            SERVE:   if (enable && start)                state_n = RUN;
            RUN:     if (enable && tick && y_hit_high)   state_n = HOLD;
            HOLD:    if (enable && tick && hold_done)    state_n = SERVE;
            default:                                     state_n = SERVE;
        endcase
    end

    // serve_dx remembers the last serve direction so successive serves alternate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ball_x   <= X_CTR;
            ball_y   <= Y_CTR;
            dx       <= 1'b1;
            dy       <= 1'b0;
            serve_dx <= 1'b1;
            hold_cnt <= '0;
            running  <= 1'b0;
            bounce   <= 1'b0;
            miss     <= 1'b0;
        end else begin
            bounce  <= 1'b0;
            miss    <= 1'b0;
            running <= (state_n == RUN);
            if (enable && tick) begin
                case (state)
                    RUN: begin
                        ball_x   <= x_next;
                        dx       <= dx_next;
                        ball_y   <= y_next;
                        dy       <= dy_next;
                        // A miss outranks any simultaneous wall reflection.
                        bounce   <= (x_hit_low | x_hit_high | y_hit_low) & ~y_hit_high;
                        miss     <= y_hit_high;
                        hold_cnt <= '0;
                    end
                    HOLD: begin
                        if (hold_done) begin
                            ball_x   <= X_CTR;
                            ball_y   <= Y_CTR;
                            dy       <= 1'b0;
                            dx       <= ~serve_dx;
                            serve_dx <= ~serve_dx;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion with a cycle-level reference model.
module tb_ball_motion;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        reset, tick, enable, start;
    logic [9:0]  ball_x, ball_y;
    logic        running, bounce, miss;
    ball_state_e state_dbg;

    int checks = 0;
    int errors = 0;
    int tcount = 0;
    bit cmp_en = 1'b0;

    // model state: mode 0 serve, 1 run, 2 hold
    int m_x = 316, m_y = 236, m_dx = 1, m_dy = 0, m_mode = 0, m_hold = 0, m_rally = 0;
    int m_bounce = 0, m_miss = 0, m_running = 0;
    int nx, ny, hx, hy;

    always #5 clk = ~clk;

    ball_motion dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .enable    (enable),
        .start     (start),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .running   (running),
        .bounce    (bounce),
        .miss      (miss),
        .state_dbg (state_dbg)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ball moves 4 px per tick, clamps at 0 / 632 / 472.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_x = 316; m_y = 236; m_dx = 1; m_dy = 0; m_mode = 0; m_hold = 0;
            m_rally = 0; m_bounce = 0; m_miss = 0; m_running = 0;
        end else begin
            m_bounce = 0;
            m_miss   = 0;
            if (enable) begin
                if (m_mode == 0) begin
                    if (start) m_mode = 1;
                end else if (m_mode == 1) begin
                    if (tick) begin
                        hx = 0; hy = 0;
                        nx = (m_dx != 0) ? m_x + 4 : m_x - 4;
                        if (nx >= 632)    begin nx = 632; m_dx = 0; hx = 1; end
                        else if (nx <= 0) begin nx = 0;   m_dx = 1; hx = 1; end
                        ny = (m_dy != 0) ? m_y + 4 : m_y - 4;
                        if (m_dy != 0 && ny >= 472) begin
                            ny = 472; m_miss = 1; m_mode = 2; m_hold = 0;
                        end else if (m_dy == 0 && ny <= 0) begin
                            ny = 0; m_dy = 1; hy = 1;
                        end
                        m_x = nx;
                        m_y = ny;
                        m_bounce = ((hx != 0 || hy != 0) && m_miss == 0) ? 1 : 0;
                    end
                end else if (tick) begin
                    m_hold++;
                    if (m_hold == 10) begin
                        m_mode = 0; m_x = 316; m_y = 236; m_dy = 0; m_hold = 0;
                        m_rally++;
                        m_dx = (m_rally % 2 == 0) ? 1 : 0;
                    end
                end
            end
            m_running = (m_mode == 1) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_ball_x",  int'(ball_x),    m_x);
            check("cmp_ball_y",  int'(ball_y),    m_y);
            check("cmp_running", int'(running),   m_running);
            check("cmp_bounce",  int'(bounce),    m_bounce);
            check("cmp_miss",    int'(miss),      m_miss);
            check("cmp_state",   int'(state_dbg), m_mode);
        end
    end

    task automatic do_tick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        tcount++;
    endtask

    task automatic run_to(input int k);
        while (tcount < k) do_tick();
    endtask

    task automatic serve();
        @(negedge clk) begin start = 1'b1; tick = 1'b1; end
        @(negedge clk) begin start = 1'b0; tick = 1'b0; end
        tcount = 0;
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; enable = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_x", int'(ball_x), 316);
        check("rst_y", int'(ball_y), 236);
        check("rst_running", int'(running), 0);
        check("rst_pulses", int'(bounce | miss), 0);
        reset  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // disabled: start and 20 ticks ignored
        start = 1'b1;
        repeat (20) do_tick();
        start = 1'b0;
        check("dis_x", int'(ball_x), 316);
        check("dis_running", int'(running), 0);
        enable = 1'b1;

        serve();
        check("serve_running", int'(running), 1);
        check("serve_no_move", int'(ball_x), 316);
        do_tick();
        check("t1_x", int'(ball_x), 320);
        check("t1_y", int'(ball_y), 232);

        run_to(59);
        check("top_y", int'(ball_y), 0);
        check("top_bounce", int'(bounce), 1);
        @(negedge clk);
        check("top_bounce_width", int'(bounce), 0);
        run_to(60);
        check("t60_y", int'(ball_y), 4);

        run_to(79);
        check("right_x", int'(ball_x), 632);
        check("right_bounce", int'(bounce), 1);
        run_to(80);
        check("t80_x", int'(ball_x), 628);

        run_to(177);
        check("miss_y", int'(ball_y), 472);
        check("miss_x", int'(ball_x), 240);
        check("miss_pulse", int'(miss), 1);
        check("miss_running", int'(running), 0);
        @(negedge clk);
        check("miss_width", int'(miss), 0);
        run_to(186);
        check("hold_x", int'(ball_x), 240);
        check("hold_y", int'(ball_y), 472);
        check("hold_state", int'(state_dbg), 2);
        run_to(187);
        check("recentre_x", int'(ball_x), 316);
        check("recentre_y", int'(ball_y), 236);
        check("recentre_state", int'(state_dbg), 0);

        serve();
        do_tick();
        check("serve2_x", int'(ball_x), 312);
        check("serve2_y", int'(ball_y), 232);

        // back-to-back ticks, three consecutive cycles
        @(negedge clk) tick = 1'b1;
        repeat (3) @(negedge clk);
        tick = 1'b0;
        check("b2b_x", int'(ball_x), 300);
        check("b2b_y", int'(ball_y), 220);

        enable = 1'b0;
        do_tick();
        check("freeze_x", int'(ball_x), 300);
        check("freeze_running", int'(running), 1);
        enable = 1'b1;

        // asynchronous reset between edges, with a tick held across an edge
        @(posedge clk);
        #2;
        reset = 1'b0;
        tick  = 1'b1;
        #1;
        check("async_x", int'(ball_x), 316);
        check("async_y", int'(ball_y), 236);
        check("async_running", int'(running), 0);
        @(posedge clk);
        #1;
        check("async_tick_x", int'(ball_x), 316);
        @(negedge clk) begin tick = 1'b0; reset = 1'b1; end
        @(negedge clk);
        check("post_rst_state", int'(state_dbg), 0);
        check("post_rst_y", int'(ball_y), 236);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
